// File: rtl/key_cmd_pkg.sv
// Shared types and helpers for the keyboard command encoder.
// Commands are {1'b1, key index}; all-zero means "no command".
package key_cmd_pkg;

    localparam int MAX_KEYS  = 32;
    localparam int MAX_CMD_W = 6;

    localparam logic [MAX_CMD_W-1:0] CMD_NONE = '0;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        HOLD
    } rep_state_e;

    // idx_w is the width of the key index; the marker bit sits just above it
    function automatic logic [MAX_CMD_W-1:0] encode_cmd(input int unsigned index,
                                                        input int unsigned idx_w);
        return MAX_CMD_W'(index) | (MAX_CMD_W'(1) << idx_w);
    endfunction

    // Lowest set bit wins; returns 0 for an all-zero vector (caller checks |v)
    function automatic logic [4:0] find_lowest(input logic [MAX_KEYS-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = MAX_KEYS - 1; i >= 0; i--)
            if (v[i]) idx = 5'(i);
        return idx;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; a push into a full FIFO is still accepted when a
// pop happens in the same cycle, otherwise it is dropped and flagged stickily.
module cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign valid   = !empty;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)         wr_ptr   <= wr_ptr + (AW+1)'(1);
            if (do_pop)          rd_ptr   <= rd_ptr + (AW+1)'(1);
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/key_repeat_encoder.sv
// Priority-encodes held keys into game commands with press detection and
// per-key auto-repeat, queued toward game control through a small FIFO.
module key_repeat_encoder
    import key_cmd_pkg::*;
#(
    parameter int                  NUM_KEYS      = 4,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK   = '1,
    parameter int                  REPEAT_DELAY  = 10,
    parameter int                  REPEAT_PERIOD = 4,
    parameter int                  DEPTH         = 4,
    parameter int                  RESET_KEY     = 0,
    localparam int                 KEY_W         = $clog2(NUM_KEYS),
    localparam int                 CMD_W         = 1 + KEY_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_level,
    output logic [CMD_W-1:0]    cmd_data,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic                overflow,
    output logic                rst_req
);
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    logic [NUM_KEYS-1:0] key_q, key_prev, press;
    logic [KEY_W-1:0]    active, cur_key;
    logic [CNT_W-1:0]    cnt;
    logic                any_key, timer_fire, push, fifo_full;
    logic [CMD_W-1:0]    push_cmd;
    rep_state_e          state;

    assign press    = key_q & ~key_prev;
    assign any_key  = |key_q;
    assign active   = KEY_W'(find_lowest(MAX_KEYS'(key_q)));
    assign push_cmd = CMD_W'(encode_cmd(int'(active), KEY_W));

    // Timers only fire while still tracking the same key; a change of
    // active key retargets silently instead.
    assign timer_fire = (state == DELAY || state == REPEAT) && (cnt == '0) && (active == cur_key);
    assign push       = any_key && (press[active] || timer_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q    <= '0;
            key_prev <= '0;
            rst_req  <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            cur_key  <= '0;
        end else begin
            key_q    <= key_level;
            key_prev <= key_q;
            rst_req  <= key_level[RESET_KEY];
            if (!any_key) begin
                state <= IDLE;
            end else if (press[active] || state == IDLE || active != cur_key) begin
                cur_key <= active;
                if (REPEAT_MASK[active]) begin
                    state <= DELAY;
                    cnt   <= DELAY_LOAD;
                end else begin
                    state <= HOLD;
                end
            end else begin
                case (state)
                    DELAY: begin
                        if (cnt == '0) begin
                            state <= REPEAT;
                            cnt   <= PERIOD_LOAD;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    REPEAT: cnt <= (cnt == '0) ? PERIOD_LOAD : cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_cmd),
        .pop       (cmd_ready),
        .head      (cmd_data),
        .valid     (cmd_valid),
        .full      (fifo_full),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_key_repeat_encoder.sv
// Directed scenarios for key_repeat_encoder; expected commands go into a
// scoreboard queue and a negedge monitor checks every accepted output.
module tb_key_repeat_encoder;

    logic       clk = 1'b0;
    logic       rst, cmd_ready, cmd_valid, overflow, rst_req;
    logic [3:0] key_level;
    logic [2:0] cmd_data;

    int cyc    = 0;
    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] cmd;
        int         at;   // expected visible cycle, -1 when backpressure makes it irrelevant
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    key_repeat_encoder #(
        .NUM_KEYS      (4),
        .REPEAT_MASK   (4'b0110),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4),
        .DEPTH         (4),
        .RESET_KEY     (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_level (key_level),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .overflow  (overflow),
        .rst_req   (rst_req)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_cmd: got %b at cycle %0d, expected no command", cmd_data, cyc);
            end else begin
                e = sb.pop_front();
                if (cmd_data !== e.cmd || (e.at >= 0 && cyc != e.at)) begin
                    n_fail++;
                    $display("FAIL cmd_out: got %b at cycle %0d, expected %b at cycle %0d",
                             cmd_data, cyc, e.cmd, e.at);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_cmd(input logic [2:0] c, input int at);
        exp_t x;
        x.cmd = c;
        x.at  = at;
        sb.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1; key_level = '0; cmd_ready = 1'b1;
        tick(3);
        check("reset_valid",    cmd_valid, 0);
        check("reset_data",     cmd_data,  0);
        check("reset_overflow", overflow,  0);
        check("reset_rst_req",  rst_req,   0);
        rst = 1'b0;
        tick(3);

        // single repeating key
        k = cyc; key_level = 4'b0010;
        exp_cmd(3'b101, k+2);  exp_cmd(3'b101, k+12); exp_cmd(3'b101, k+16);
        exp_cmd(3'b101, k+20); exp_cmd(3'b101, k+24);
        tick(25); key_level = '0;
        tick(10);
        check("s1_drained", sb.size(), 0);

        // non-repeating key 0, also the reset-request key
        k = cyc; key_level = 4'b0001;
        exp_cmd(3'b100, k+2);
        check("s2_rst_req_lag", rst_req, 0);
        tick(1);  check("s2_rst_req_on", rst_req, 1);
        tick(29); key_level = '0;
        check("s2_rst_req_held", rst_req, 1);
        tick(1);  check("s2_rst_req_off", rst_req, 0);
        tick(8);
        check("s2_drained", sb.size(), 0);

        // preemption by a higher-priority key, then fall back with a delay restart
        k = cyc; key_level = 4'b0100;
        exp_cmd(3'b110, k+2);
        tick(10); key_level = 4'b0110;
        exp_cmd(3'b101, k+12); exp_cmd(3'b101, k+22); exp_cmd(3'b101, k+26);
        tick(17); key_level = 4'b0100;
        exp_cmd(3'b110, k+39);
        tick(13); key_level = '0;
        tick(8);
        check("s3_drained", sb.size(), 0);

        // backpressure overflows, drain keeps the sticky flag
        cmd_ready = 1'b0;
        key_level = 4'b0010;
        repeat (4) exp_cmd(3'b101, -1);
        tick(40); key_level = '0;
        check("s4_overflow_set", overflow, 1);
        check("s4_full_valid", cmd_valid, 1);
        tick(3); cmd_ready = 1'b1;
        tick(8);
        check("s4_drained_valid", cmd_valid, 0);
        check("s4_overflow_sticky", overflow, 1);
        check("s4_drained", sb.size(), 0);

        rst = 1'b1; tick(1); rst = 1'b0;
        check("rst_clears_overflow", overflow, 0);
        tick(2);

        // full FIFO with a simultaneous pop and push
        cmd_ready = 1'b0;
        k = cyc; key_level = 4'b0010;
        repeat (5) exp_cmd(3'b101, -1);
        tick(23); cmd_ready = 1'b1;
        tick(1);  cmd_ready = 1'b0; key_level = '0;
        check("s5_no_overflow", overflow, 0);
        check("s5_still_valid", cmd_valid, 1);
        tick(6); cmd_ready = 1'b1;
        tick(8);
        check("s5_drained_valid", cmd_valid, 0);
        check("s5_overflow_clear", overflow, 0);
        check("s5_drained", sb.size(), 0);

        // reset while repeating with two entries queued
        cmd_ready = 1'b0;
        k = cyc; key_level = 4'b0010;
        tick(13); rst = 1'b1;
        tick(1);  rst = 1'b0;
        check("s6_valid_cleared", cmd_valid, 0);
        check("s6_data_cleared", cmd_data, 0);
        check("s6_overflow_clear", overflow, 0);
        cmd_ready = 1'b1;
        exp_cmd(3'b101, k+16); exp_cmd(3'b101, k+26);
        tick(13); key_level = '0;
        tick(8);
        check("s6_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
